// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and small helpers for the seven-segment scan decoder.
package seg_pkg;

    localparam int SETTLE_CYC_DEF  = 4;
    localparam int TIMEOUT_CYC_DEF = 200_000;

    localparam logic [3:0] CODE_MINUS   = 4'd10;
    localparam logic [3:0] CODE_BLANK   = 4'd11;
    localparam logic [3:0] CODE_INVALID = 4'd15;

    // Active-low patterns on segments g..a.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    function automatic logic [3:0] seg_decode(input logic [6:0] pat);
        logic [3:0] code;
        case (pat)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_MINUS: code = CODE_MINUS;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_INVALID;
        endcase
        return code;
    endfunction

    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

    function automatic logic [2:0] onehot_index(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Minus, blank and invalid slots weigh nothing in the binary value.
    function automatic logic [3:0] code_digit(input logic [3:0] code);
        return (code <= 4'd9) ? code : 4'd0;
    endfunction

    function automatic logic has_code(input logic [23:0] codes, input logic [3:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (codes[4*i +: 4] == code) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/seg_bcd2bin.sv
// Six-slot decimal-to-binary converter: walks slot 5 down to slot 0 with acc = acc*10 + digit.
module seg_bcd2bin
    import seg_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [23:0] codes,
    output logic        done,
    output logic [19:0] value
);

    conv_state_t state_r;
    logic [23:0] codes_r;
    logic [2:0]  idx_r;
    logic [19:0] acc_r;
    logic [19:0] value_r;
    logic        done_r;
    logic [19:0] acc_next_s;

    // Next accumulator value for the slot currently addressed.
    always_comb begin
        acc_next_s = (acc_r * 20'd10) + {16'd0, code_digit(codes_r[{idx_r, 2'b00} +: 4])};
    end

    // Conversion FSM; done is high for the single DONE cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= IDLE;
            codes_r <= 24'd0;
            idx_r   <= 3'd0;
            acc_r   <= 20'd0;
            value_r <= 20'd0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        codes_r <= codes;
                        acc_r   <= 20'd0;
                        idx_r   <= 3'd5;
                        state_r <= CONV;
                    end
                end
                CONV: begin
                    acc_r <= acc_next_s;
                    if (idx_r == 3'd0) begin
                        value_r <= acc_next_s;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r <= idx_r - 3'd1;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign done  = done_r;
    assign value = value_r;

endmodule

// File: rtl/seg_decoder.sv
// Multiplexed seven-segment display decoder: captures a six-digit scan and reports codes and value.
// Per-slot dot capture is built only when SEG_DEC_POINT_EN is defined.
module seg_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [5:0]  sel_in,
    input  logic [7:0]  seg_in,
    output logic [23:0] digits,
    output logic [5:0]  point,
    output logic        sign,
    output logic [19:0] data,
    output logic        frame_valid,
    output logic        err
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [5:0]    sel_r, sel_prev_r, mask_r;
    logic [6:0]    seg_r;
    logic          sel_chg_s, sample_s, tmo_fire_s, snap_req_s, pend_load_s;
    logic          smp_pend_r;
    logic [2:0]    smp_slot_r;
    logic [SW-1:0] settle_cnt_r;
    logic [TW-1:0] tmo_cnt_r;
    logic [23:0]   codes_r, pend_codes_r, conv_codes_r, start_codes_s;
    logic          snap_pend_r, busy_r, start_s, start_pend_s, conv_done_s;
    logic [19:0]   conv_value_s;
    logic [23:0]   digits_r;
    logic [19:0]   data_r;
    logic          sign_r, err_r, frame_valid_r;

    // Input registration; all detection below works on these copies.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_r      <= 6'd0;
            sel_prev_r <= 6'd0;
            seg_r      <= SEG_BLANK;
        end else begin
            sel_r      <= sel_in;
            sel_prev_r <= sel_r;
            seg_r      <= seg_in[6:0];
        end
    end

    assign sel_chg_s   = (sel_r != sel_prev_r) && is_onehot6(sel_r);
    assign tmo_fire_s  = !sel_chg_s && (tmo_cnt_r == TW'(TIMEOUT_CYC - 1));
    assign sample_s    = smp_pend_r && (settle_cnt_r == SW'(SETTLE_CYC)) && !sel_chg_s && !tmo_fire_s;
    assign snap_req_s  = (mask_r == 6'h3F);
    assign pend_load_s = snap_req_s && (busy_r || snap_pend_r);

    // Settle tracking: a new valid select restarts the count and abandons any pending sample.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            smp_pend_r   <= 1'b0;
            smp_slot_r   <= 3'd0;
            settle_cnt_r <= SW'(0);
        end else if (sel_chg_s) begin
            smp_pend_r   <= 1'b1;
            smp_slot_r   <= onehot_index(sel_r);
            settle_cnt_r <= SW'(1);
        end else if (tmo_fire_s || sample_s) begin
            smp_pend_r <= 1'b0;
        end else if (smp_pend_r) begin
            settle_cnt_r <= settle_cnt_r + SW'(1);
        end
    end

    // Inactivity timer, saturating once it has fired.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt_r <= TW'(0);
        end else if (sel_chg_s) begin
            tmo_cnt_r <= TW'(0);
        end else if (tmo_cnt_r != TW'(TIMEOUT_CYC)) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end
    end

    // Slot capture; the mask clears on snapshot while a new sample may still land.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            codes_r <= 24'hBBBBBB;
            mask_r  <= 6'd0;
        end else begin
            if (sample_s) codes_r[{smp_slot_r, 2'b00} +: 4] <= seg_decode(seg_r);
            if (tmo_fire_s) mask_r <= 6'd0;
            else mask_r <= (snap_req_s ? 6'd0 : mask_r) | (sample_s ? (6'd1 << smp_slot_r) : 6'd0);
        end
    end

    // A held frame always goes first so frames convert in arrival order.
    always_comb begin
        start_s       = 1'b0;
        start_pend_s  = 1'b0;
        start_codes_s = codes_r;
        if (!busy_r && snap_pend_r) begin
            start_s       = 1'b1;
            start_pend_s  = 1'b1;
            start_codes_s = pend_codes_r;
        end else if (!busy_r && snap_req_s) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // One-deep holding register and converter occupancy.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend_codes_r <= 24'hBBBBBB;
            snap_pend_r  <= 1'b0;
            conv_codes_r <= 24'hBBBBBB;
            busy_r       <= 1'b0;
        end else begin
            if (pend_load_s) begin
                pend_codes_r <= codes_r;
                snap_pend_r  <= 1'b1;
            end else if (start_pend_s) begin
                snap_pend_r <= 1'b0;
            end
            if (start_s) begin
                conv_codes_r <= start_codes_s;
                busy_r       <= 1'b1;
            end else if (conv_done_s) begin
                busy_r <= 1'b0;
            end
        end
    end

    seg_bcd2bin u_bcd2bin (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start_s),
        .codes     (start_codes_s),
        .done      (conv_done_s),
        .value     (conv_value_s)
    );

    // Output registers, loaded together with the frame_valid pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            digits_r      <= 24'hBBBBBB;
            data_r        <= 20'd0;
            sign_r        <= 1'b0;
            err_r         <= 1'b0;
            frame_valid_r <= 1'b0;
        end else if (conv_done_s) begin
            digits_r      <= conv_codes_r;
            data_r        <= conv_value_s;
            sign_r        <= has_code(conv_codes_r, CODE_MINUS);
            err_r         <= has_code(conv_codes_r, CODE_INVALID);
            frame_valid_r <= 1'b1;
        end else begin
            frame_valid_r <= 1'b0;
        end
    end

    assign digits      = digits_r;
    assign data        = data_r;
    assign sign        = sign_r;
    assign err         = err_r;
    assign frame_valid = frame_valid_r;

`ifdef SEG_DEC_POINT_EN
    logic       dot_r;
    logic [5:0] dots_r, pend_dots_r, conv_dots_r, point_r;

    // Dot path follows the same sample / hold / convert steps as the codes.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dot_r       <= 1'b0;
            dots_r      <= 6'd0;
            pend_dots_r <= 6'd0;
            conv_dots_r <= 6'd0;
            point_r     <= 6'd0;
        end else begin
            dot_r <= ~seg_in[7];
            if (sample_s) dots_r[smp_slot_r] <= dot_r;
            if (pend_load_s) pend_dots_r <= dots_r;
            if (start_s) conv_dots_r <= start_pend_s ? pend_dots_r : dots_r;
            if (conv_done_s) point_r <= conv_dots_r;
        end
    end

    assign point = point_r;
`else
    logic unused_dot_s;
    assign unused_dot_s = seg_in[7];
    assign point        = 6'd0;
`endif

endmodule

// File: tb/tb_seg_decoder.sv
// Self-checking bench for seg_decoder: scripted and random scans against a lookup-table model.
module tb_seg_decoder;

    localparam int SETTLE = 4;
    localparam int TMO    = 2000;
    localparam int DWELL  = 12;
    localparam int BLANK  = 2;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic [5:0]  sel_in    = 6'd0;
    logic [7:0]  seg_in    = 8'hFF;
    logic [23:0] digits;
    logic [5:0]  point;
    logic        sign, frame_valid, err;
    logic [19:0] data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fv_cnt = 0;
    int fv_cyc = 0;
    int t5     = 0;
    int lat    = 14;

    logic [6:0]  pat [12] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                              7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h7F};
    logic [7:0]  frame_seg [6];
    logic [23:0] exp_digits;
    logic [5:0]  exp_point;
    logic        exp_sign, exp_err;
    logic [19:0] exp_data;

    seg_decoder #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .sel_in      (sel_in),
        .seg_in      (seg_in),
        .digits      (digits),
        .point       (point),
        .sign        (sign),
        .data        (data),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (frame_valid === 1'b1) begin
            fv_cnt <= fv_cnt + 1;
            fv_cyc <= cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: table lookup per slot, value as a positional sum of powers of ten.
    task automatic compute_expected();
        int code, val, p10;
        val = 0; p10 = 1; exp_sign = 1'b0; exp_err = 1'b0; exp_point = 6'd0;
        for (int k = 0; k < 6; k++) begin
            code = 15;
            for (int j = 0; j < 12; j++) if (frame_seg[k][6:0] == pat[j]) code = j;
            exp_digits[4*k +: 4] = 4'(code);
            if (code == 10) exp_sign = 1'b1;
            if (code == 15) exp_err = 1'b1;
            if (code < 10) val = val + code * p10;
            p10 = p10 * 10;
`ifdef SEG_DEC_POINT_EN
            exp_point[k] = ~frame_seg[k][7];
`endif
        end
        exp_data = 20'(val);
    endtask

    task automatic show_slot(input int k);
        @(negedge sys_clk);
        sel_in = 6'd1 << k;
        seg_in = frame_seg[k];
        if (k == 5) t5 = cyc;
        repeat (DWELL) @(negedge sys_clk);
        sel_in = 6'd0;
        repeat (BLANK) @(negedge sys_clk);
    endtask

    task automatic scan_frame();
        for (int k = 0; k < 6; k++) show_slot(k);
    endtask

    task automatic wait_frame(input int prev, input string name);
        int n = 0;
        while (fv_cnt == prev && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        checks++; if (fv_cnt == prev) begin errors++; $display("FAIL %s frame_valid: got no pulse, want pulse within 300 cycles", name); end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b1;
        #1 sys_rst_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checks++; if (digits !== 24'hBBBBBB) begin errors++; $display("FAIL reset digits: got %h want bbbbbb", digits); end
        checks++; if (point !== 6'd0) begin errors++; $display("FAIL reset point: got %b want 000000", point); end
        checks++; if (sign !== 1'b0) begin errors++; $display("FAIL reset sign: got %b want 0", sign); end
        checks++; if (data !== 20'd0) begin errors++; $display("FAIL reset data: got %0d want 0", data); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset frame_valid: got %b want 0", frame_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", err); end
    endtask

    task automatic test_frame_123456();
        int prev;
        frame_seg = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        prev = fv_cnt;
        scan_frame();
        wait_frame(prev, "f123456");
        if (fv_cnt != prev) lat = fv_cyc - t5;
        if (lat < 8 || lat > 40) lat = 14;
        checks++; if (data !== 20'd123456) begin errors++; $display("FAIL f123456 data: got %0d want 123456", data); end
        checks++; if (digits !== 24'h123456) begin errors++; $display("FAIL f123456 digits: got %h want 123456", digits); end
        checks++; if (sign !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL f123456 sign/err: got %b/%b want 0/0", sign, err); end
        checks++; if (point !== 6'd0) begin errors++; $display("FAIL f123456 point: got %b want 000000", point); end
        repeat (30) @(negedge sys_clk);
        checks++; if (fv_cnt != prev + 1) begin errors++; $display("FAIL f123456 pulses: got %0d want 1", fv_cnt - prev); end
    endtask

    task automatic test_minus42();
        int prev;
        frame_seg = '{8'hA4, 8'h99, 8'hBF, 8'hFF, 8'hFF, 8'hFF};
        prev = fv_cnt;
        scan_frame();
        wait_frame(prev, "minus42");
        checks++; if (digits !== 24'hBBBA42) begin errors++; $display("FAIL minus42 digits: got %h want bbba42", digits); end
        checks++; if (data !== 20'd42) begin errors++; $display("FAIL minus42 data: got %0d want 42", data); end
        checks++; if (sign !== 1'b1) begin errors++; $display("FAIL minus42 sign: got %b want 1", sign); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL minus42 err: got %b want 0", err); end
    endtask

    task automatic test_point();
        int prev;
        logic [5:0] want;
        frame_seg = '{8'hC0, 8'hC0, 8'hC0, 8'h40, 8'hC0, 8'hC0};
`ifdef SEG_DEC_POINT_EN
        want = 6'b001000;
`else
        want = 6'b000000;
`endif
        prev = fv_cnt;
        scan_frame();
        wait_frame(prev, "point");
        checks++; if (point !== want) begin errors++; $display("FAIL point point: got %b want %b", point, want); end
        checks++; if (digits !== 24'h000000 || data !== 20'd0) begin errors++; $display("FAIL point digits/data: got %h/%0d want 000000/0", digits, data); end
    endtask

    task automatic test_invalid();
        int prev;
        frame_seg = '{8'hB0, 8'hD5, 8'hF8, 8'hC0, 8'hC0, 8'hC0};
        prev = fv_cnt;
        scan_frame();
        wait_frame(prev, "invalid");
        checks++; if (digits[7:4] !== 4'hF) begin errors++; $display("FAIL invalid slot1: got %h want f", digits[7:4]); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL invalid err: got %b want 1", err); end
        checks++; if (data !== 20'd703) begin errors++; $display("FAIL invalid data: got %0d want 703", data); end
    endtask

    task automatic test_random();
        int prev, r;
        logic [6:0] p;
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < 6; k++) begin
                r = $urandom_range(0, 13);
                p = (r < 12) ? pat[r] : 7'($urandom);
                frame_seg[k] = {1'($urandom_range(0, 1)), p};
            end
            compute_expected();
            prev = fv_cnt;
            scan_frame();
            wait_frame(prev, "random");
            checks++; if (digits !== exp_digits) begin errors++; $display("FAIL random%0d digits: got %h want %h", it, digits, exp_digits); end
            checks++; if (data !== exp_data) begin errors++; $display("FAIL random%0d data: got %0d want %0d", it, data, exp_data); end
            checks++; if (sign !== exp_sign || err !== exp_err) begin errors++; $display("FAIL random%0d sign/err: got %b/%b want %b/%b", it, sign, err, exp_sign, exp_err); end
            checks++; if (point !== exp_point) begin errors++; $display("FAIL random%0d point: got %b want %b", it, point, exp_point); end
        end
    endtask

    task automatic test_timeout();
        int prev;
        frame_seg = '{8'hC0, 8'hC0, 8'hC0, 8'h90, 8'h90, 8'h90};
        show_slot(3);
        show_slot(4);
        show_slot(5);
        repeat (TMO + 50) @(negedge sys_clk);
        frame_seg = '{8'hF8, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        prev = fv_cnt;
        scan_frame();
        wait_frame(prev, "timeout");
        repeat (40) @(negedge sys_clk);
        checks++; if (fv_cnt != prev + 1) begin errors++; $display("FAIL timeout pulses: got %0d want 1", fv_cnt - prev); end
        checks++; if (data !== 20'd7) begin errors++; $display("FAIL timeout data: got %0d want 7", data); end
        checks++; if (digits !== 24'h000007) begin errors++; $display("FAIL timeout digits: got %h want 000007", digits); end
    endtask

    task automatic test_reset_mid_conv();
        int prev, t;
        frame_seg = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        prev = fv_cnt;
        for (int k = 0; k < 5; k++) show_slot(k);
        @(negedge sys_clk);
        sel_in = 6'b100000;
        seg_in = frame_seg[5];
        t = cyc;
        while (cyc < t + lat - 5) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        sel_in    = 6'd0;
        @(negedge sys_clk);
        checks++; if (frame_valid !== 1'b0 || digits !== 24'hBBBBBB) begin errors++; $display("FAIL midconv in-reset: got fv=%b digits=%h want 0/bbbbbb", frame_valid, digits); end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        checks++; if (fv_cnt != prev) begin errors++; $display("FAIL midconv pulses: got %0d want 0", fv_cnt - prev); end
        checks++; if (digits !== 24'hBBBBBB || data !== 20'd0) begin errors++; $display("FAIL midconv digits/data: got %h/%0d want bbbbbb/0", digits, data); end
        checks++; if (sign !== 1'b0 || err !== 1'b0 || point !== 6'd0) begin errors++; $display("FAIL midconv sign/err/point: got %b/%b/%b want 0/0/0", sign, err, point); end
    endtask

    initial begin
        test_reset();
        test_frame_123456();
        test_minus42();
        test_point();
        test_invalid();
        test_random();
        test_timeout();
        test_reset_mid_conv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_decoder.md
SEG_DECODER -- requirements
Module: seg_decoder

Interface
REQ-001 Parameter SETTLE_CYC, default 4: cycles after a sel change before seg is sampled.
REQ-002 Parameter TIMEOUT_CYC, default 200_000: cycles without a sel change before the partial frame is discarded.
REQ-003 sys_clk  input  1  system clock, all logic on rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sel_in  input  6  digit select, active-high, one-hot; bit k selects slot k, slot 0 is the least significant.
REQ-006 seg_in  input  8  segment bus, active-low; seg_in[7] is the dot, seg_in[6:0] are segments g..a.
REQ-007 digits  output  24  six 4-bit slot codes; slot k is digits[4k+3:4k].
REQ-008 point  output  6  dot state per slot, 1 = dot lit.
REQ-009 sign  output  1  1 when any slot decoded as minus.
REQ-010 data  output  20  binary value of the decimal digits.
REQ-011 frame_valid  output  1  single-cycle pulse when digits, point, sign, data and err update.
REQ-012 err  output  1  1 when the last frame contained an invalid segment pattern.

Function
REQ-013 sel_in and seg_in SHALL be registered once on entry; all detection uses the registered values.
REQ-014 Sel change SHALL mean registered sel differs from the previous cycle and is exactly one-hot; zero or multi-hot values are ignored and do not restart the settle count.
REQ-015 SETTLE_CYC cycles after a sel change, seg SHALL be sampled once into the selected slot, and the slot mask bit SHALL be set.
REQ-016 If sel changes again before sampling, the pending sample SHALL be abandoned and the count restarts for the new slot.
REQ-017 Segment decode (seg_in[6:0] hex) SHALL be: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 3F->10 (minus), 7F->11 (blank); any other pattern ->15 (invalid).
REQ-018 When the slot mask reaches 6'b111111, the six codes and dots SHALL be snapshotted, the mask cleared, and a conversion started; capture of the next frame continues in parallel.
REQ-019 Conversion FSM SHALL use states IDLE -> CONV (6 cycles, slot 5 down to 0, acc = acc*10 + d; d = 0 for codes 10, 11, 15) -> DONE (1 cycle) -> IDLE.
REQ-020 Accumulator SHALL be 20 bits; the maximum 999999 fits, so no saturation is required.
REQ-021 In DONE, the outputs SHALL update and frame_valid SHALL pulse; latency from snapshot to pulse is 7 cycles.
REQ-022 A snapshot requested while CONV/DONE is active SHALL be held in a one-deep pending register and converted immediately after DONE; a third frame overwrites the pending one.
REQ-023 A timeout counter SHALL count cycles since the last valid sel change; at TIMEOUT_CYC it SHALL clear the slot mask and pending sample; outputs are retained.
REQ-024 sign SHALL be 1 when any snapshot slot code equals 10; err SHALL be 1 when any slot code equals 15.

Reset
REQ-025 On reset: digits = 24'hBBBBBB (all blank), point = 0, sign = 0, data = 0, frame_valid = 0, err = 0; FSM in IDLE; mask, pending flags and counters cleared.
REQ-026 Reset mid-conversion SHALL abort the conversion without any frame_valid pulse.

Configuration
REQ-027 Macro SEG_DEC_POINT_EN: when defined, the dot is captured per slot (point[k] = ~seg_in[7] at sample time).
REQ-028 When SEG_DEC_POINT_EN is undefined, point SHALL be constant 0, seg_in[7] is ignored, and no dot storage is generated.

Structure
REQ-029 Shared package seg_pkg SHALL hold: code constants CODE_MINUS = 10, CODE_BLANK = 11, CODE_INVALID = 15; the ten digit segment patterns plus the minus and blank patterns; and the SETTLE_CYC and TIMEOUT_CYC defaults.
REQ-030 Sub-module seg_bcd2bin SHALL contain the conversion FSM and accumulator (inputs: start, 24-bit codes; outputs: done, 20-bit value).

Verification
REQ-031 Drive a 1 ms multiplexed scan showing 123456, no dots -> frame_valid, data = 123456, digits = 24'h123456, sign = 0, err = 0.
REQ-032 Scan "-42" (slots 5..3 blank, slot 2 minus) -> digits = 24'hBBBA42, data = 42, sign = 1.
REQ-033 Slot 3 shows 8'h40 (digit 0 with dot lit), SEG_DEC_POINT_EN defined -> point = 6'b001000; macro undefined -> point = 0.
REQ-034 Slot 1 shows 7'h55 -> digits[7:4] = 4'hF, err = 1, slot contributes 0 to data.
REQ-035 Stop sel after 3 slots for more than 200_000 cycles, then scan a full frame of 000007 -> exactly one frame_valid, data = 7.
REQ-036 Assert reset 3 cycles into CONV -> no frame_valid, all outputs at their reset values.
